// File: rtl/regs_seg_display_pkg.sv
// Shared constants for the regs display: active-low segment patterns,
// converter state encoding and the nibble-to-segment decode.
package regs_seg_display_pkg;

  localparam int REGS_W = 14;
  localparam int BCD_W  = 16;
  localparam logic [REGS_W-1:0] OVF_LIMIT = 14'd10000;

  // Patterns are {g,f,e,d,c,b,a}; a 0 lights the segment.
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } conv_state_e;

  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    logic [6:0] pat;
    case (nib)
      4'd0:    pat = SEG_0;
      4'd1:    pat = SEG_1;
      4'd2:    pat = SEG_2;
      4'd3:    pat = SEG_3;
      4'd4:    pat = SEG_4;
      4'd5:    pat = SEG_5;
      4'd6:    pat = SEG_6;
      4'd7:    pat = SEG_7;
      4'd8:    pat = SEG_8;
      4'd9:    pat = SEG_9;
      default: pat = SEG_BLANK;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/regs_seg_display_bin2bcd_seq.sv
// Sequential double-dabble converter: one capture cycle, 14 add-3/shift
// cycles, one cycle to publish the result.
module bin2bcd_seq
  import regs_seg_display_pkg::*;
(
  input  logic                clock_i,
  input  logic                reset_i,
  input  logic                start,
  input  logic [REGS_W-1:0]   bin,
  output logic [BCD_W-1:0]    bcd,
  output logic                busy
);

  conv_state_e       state_q;
  logic [REGS_W-1:0] shift_q;
  logic [REGS_W-1:0] shift_d;
  logic [BCD_W-1:0]  scratch_q;
  logic [BCD_W-1:0]  scratch_d;
  logic [BCD_W-1:0]  scratch_adj;
  logic [3:0]        iter_q;
  logic [BCD_W-1:0]  bcd_q;
  logic              busy_q;

  genvar gi;
  generate
    for (gi = 0; gi < BCD_W / 4; gi++) begin : g_adj
      assign scratch_adj[gi*4 +: 4] = (scratch_q[gi*4 +: 4] >= 4'd5) ?
                                      scratch_q[gi*4 +: 4] + 4'd3 :
                                      scratch_q[gi*4 +: 4];
    end
  endgenerate

  // The whole {scratch, shift} word moves left by one after adjustment.
  assign scratch_d = {scratch_adj[BCD_W-2:0], shift_q[REGS_W-1]};
  assign shift_d   = {shift_q[REGS_W-2:0], 1'b0};

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      scratch_q <= '0;
      iter_q    <= '0;
      bcd_q     <= '0;
      busy_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            shift_q   <= bin;
            scratch_q <= '0;
            iter_q    <= '0;
            busy_q    <= 1'b1;
            state_q   <= SHIFT;
          end
        end
        SHIFT: begin
          scratch_q <= scratch_d;
          shift_q   <= shift_d;
          iter_q    <= iter_q + 4'd1;
          if (iter_q == 4'd13) begin
            state_q <= DONE;
          end
        end
        DONE: begin
          bcd_q   <= scratch_q;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bcd  = bcd_q;
  assign busy = busy_q;

endmodule

// File: rtl/regs_seg_display.sv
// Display end of the regs bus: change detection, BCD conversion and a
// multiplexed active-low 4-digit seven-segment driver.
module regs_seg_display
  import regs_seg_display_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 100000,
  parameter logic        BLANK_LZ    = 1'b1
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic [REGS_W-1:0] regs_i,
  output logic [6:0]        seg_o,
  output logic [3:0]        an_o,
  output logic              dp_o,
  output logic [BCD_W-1:0]  bcd_o,
  output logic              busy_o
);

  localparam logic [19:0] DIV_LAST = 20'(REFRESH_DIV - 1);

  logic [REGS_W-1:0] last_q;
  logic              ovf_q;
  logic              start;
  logic              accept;
  logic              ovf_live;
  logic              ovf;
  logic [19:0]       cnt_q;
  logic [1:0]        sel_q;
  logic [3:0]        nib_zero;
  logic [3:0]        lead_zero;
  logic [3:0]        nib;
  logic [6:0]        seg_d;
  logic [6:0]        seg_q;
  logic [3:0]        an_q;
  logic              dp_q;

  bin2bcd_seq u_conv (
    .clock_i (clock_i),
    .reset_i (reset_i),
    .start   (start),
    .bin     (regs_i),
    .bcd     (bcd_o),
    .busy    (busy_o)
  );

  assign start  = (regs_i != last_q);
  assign accept = start && !busy_o;

  // While idle, last_q is exactly the value behind bcd_o; while busy, ovf_q
  // remembers the flag that belongs to the result still on bcd_o.
  assign ovf_live = (last_q >= OVF_LIMIT);
  assign ovf      = busy_o ? ovf_q : ovf_live;

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      last_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      if (accept) begin
        last_q <= regs_i;
      end
      if (!busy_o) begin
        ovf_q <= ovf_live;
      end
    end
  end

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      cnt_q <= '0;
      sel_q <= '0;
    end else if (cnt_q == DIV_LAST) begin
      cnt_q <= '0;
      sel_q <= sel_q + 2'd1;
    end else begin
      cnt_q <= cnt_q + 20'd1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_zero
      assign nib_zero[gi] = (bcd_o[gi*4 +: 4] == 4'd0);
    end
    // Units digit is never blanked; higher digits blank when they and
    // everything above them are zero.
    assign lead_zero[0] = 1'b0;
    for (gi = 1; gi < 4; gi++) begin : g_lz
      assign lead_zero[gi] = &nib_zero[3:gi];
    end
  endgenerate

  assign nib = bcd_o[sel_q*4 +: 4];

  always_comb begin
    seg_d = seg_decode(nib);
    if (ovf) begin
      seg_d = SEG_DASH;
    end else if (BLANK_LZ && lead_zero[sel_q]) begin
      seg_d = SEG_BLANK;
    end
  end

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      seg_q <= SEG_BLANK;
      an_q  <= 4'hF;
      dp_q  <= 1'b1;
    end else begin
      seg_q <= seg_d;
      an_q  <= ~(4'b0001 << sel_q);
      dp_q  <= !(ovf && (sel_q == 2'd0));
    end
  end

  assign seg_o = seg_q;
  assign an_o  = an_q;
  assign dp_o  = dp_q;

endmodule

// File: tb/tb_regs_seg_display.sv
// Scoreboard bench for regs_seg_display with a fast refresh divider; a second
// instance runs without leading-zero blanking on the same stimulus.
module tb_regs_seg_display;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [13:0] regs = '0;
  logic [6:0]  seg, seg0;
  logic [3:0]  an, an0;
  logic        dp, dp0;
  logic [15:0] bcd, bcd0;
  logic        busy, busy0;

  int n_cmp = 0;
  int n_bad = 0;
  logic [15:0] sb_q[$];

  always #5 clk = ~clk;

  regs_seg_display #(.REFRESH_DIV(4), .BLANK_LZ(1'b1)) dut (
    .clock_i(clk), .reset_i(rst_n), .regs_i(regs),
    .seg_o(seg), .an_o(an), .dp_o(dp), .bcd_o(bcd), .busy_o(busy)
  );

  regs_seg_display #(.REFRESH_DIV(4), .BLANK_LZ(1'b0)) dut0 (
    .clock_i(clk), .reset_i(rst_n), .regs_i(regs),
    .seg_o(seg0), .an_o(an0), .dp_o(dp0), .bcd_o(bcd0), .busy_o(busy0)
  );

  function automatic logic [6:0] pat(input logic [3:0] d);
    case (d)
      4'd0: return 7'h40;  4'd1: return 7'h79;  4'd2: return 7'h24;
      4'd3: return 7'h30;  4'd4: return 7'h19;  4'd5: return 7'h12;
      4'd6: return 7'h02;  4'd7: return 7'h78;  4'd8: return 7'h00;
      4'd9: return 7'h10;  default: return 7'h7F;
    endcase
  endfunction

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic logic [6:0] exp_seg(input logic [15:0] b, input int k, input bit lz);
    bit all_zero = 1'b1;
    for (int j = k; j < 4; j++) if (b[j*4 +: 4] != 4'd0) all_zero = 1'b0;
    if (lz && k > 0 && all_zero) return 7'h7F;
    return pat(b[k*4 +: 4]);
  endfunction

  function automatic int an_idx(input logic [3:0] a);
    case (a)
      4'hE: return 0;  4'hD: return 1;  4'hB: return 2;  4'h7: return 3;
      default: return -1;
    endcase
  endfunction

  task automatic drive_value(input int v);
    @(posedge clk);
    #1 regs = 14'(v);
    if (v < 10000) sb_q.push_back(to_bcd(v));
  endtask

  // Counts sampled cycles with busy high until it falls; bounded.
  task automatic wait_done(output int cnt, output bit timeout);
    bit seen = 1'b0;
    cnt = 0;
    timeout = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (busy) begin
        seen = 1'b1;
        cnt++;
      end else if (seen) begin
        timeout = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    logic [29:0] got;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i == 0) #7; else #10;
      got = {seg, an, dp, bcd, busy};
      n_cmp++;
      if (got !== {7'h7F, 4'hF, 1'b1, 16'h0000, 1'b0}) begin
        n_bad++;
        $display("FAIL reset_hold[%0d]: got %h required %h", i, got, {7'h7F, 4'hF, 1'b1, 16'h0000, 1'b0});
      end
    end
    #3 rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (an !== 4'hE) begin
      n_bad++;
      $display("FAIL first_an: got %h required E", an);
    end
    $display("reset: done, an=%h bcd=%h", an, bcd);
  endtask

  task automatic test_convert_1234();
    int cnt, occ[4], idx, prev;
    bit to;
    logic [15:0] exp;
    drive_value(1234);
    wait_done(cnt, to);
    n_cmp++;
    if (to || cnt != 15) begin
      n_bad++;
      $display("FAIL busy_len_1234: got %0d cycles (timeout=%0d) required 15", cnt, to);
    end
    exp = sb_q.pop_front();
    n_cmp++;
    if (bcd !== exp) begin
      n_bad++;
      $display("FAIL bcd_1234: got %h required %h", bcd, exp);
    end
    $display("convert 1234: busy=%0d cycles bcd=%h", cnt, bcd);
    occ = '{0, 0, 0, 0};
    prev = -1;
    @(posedge clk);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      idx = an_idx(an);
      n_cmp++;
      if (idx < 0 || seg !== exp_seg(exp, (idx < 0) ? 0 : idx, 1'b1) ||
          (prev >= 0 && idx != prev && idx != (prev + 1) % 4)) begin
        n_bad++;
        $display("FAIL scan_1234[%0d]: got an=%h seg=%h required one-hot-low an in order with its digit pattern", i, an, seg);
      end
      if (idx >= 0) occ[idx]++;
      prev = idx;
    end
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if (occ[k] != 4) begin
        n_bad++;
        $display("FAIL dwell_1234[%0d]: got %0d clocks required 4", k, occ[k]);
      end
    end
  endtask

  task automatic test_blank_lz();
    int cnt, idx, idx0;
    bit to;
    logic [15:0] exp;
    drive_value(7);
    wait_done(cnt, to);
    exp = sb_q.pop_front();
    n_cmp++;
    if (to || bcd !== exp || bcd0 !== exp) begin
      n_bad++;
      $display("FAIL bcd_7: got %h / %h (timeout=%0d) required %h", bcd, bcd0, to, exp);
    end
    $display("convert 7: bcd=%h", bcd);
    @(posedge clk);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      idx  = an_idx(an);
      idx0 = an_idx(an0);
      n_cmp++;
      if (idx < 0 || seg !== exp_seg(exp, (idx < 0) ? 0 : idx, 1'b1)) begin
        n_bad++;
        $display("FAIL blank_lz1[%0d]: got an=%h seg=%h required %h", i, an, seg, exp_seg(exp, (idx < 0) ? 0 : idx, 1'b1));
      end
      n_cmp++;
      if (idx0 < 0 || seg0 !== exp_seg(exp, (idx0 < 0) ? 0 : idx0, 1'b0)) begin
        n_bad++;
        $display("FAIL blank_lz0[%0d]: got an=%h seg=%h required %h", i, an0, seg0, exp_seg(exp, (idx0 < 0) ? 0 : idx0, 1'b0));
      end
    end
  endtask

  task automatic test_overflow();
    int cnt;
    bit to;
    logic [15:0] exp;
    drive_value(9999);
    wait_done(cnt, to);
    exp = sb_q.pop_front();
    n_cmp++;
    if (to || bcd !== exp) begin
      n_bad++;
      $display("FAIL bcd_9999: got %h (timeout=%0d) required %h", bcd, to, exp);
    end
    drive_value(10000);
    wait_done(cnt, to);
    n_cmp++;
    if (to || cnt != 15) begin
      n_bad++;
      $display("FAIL busy_len_10000: got %0d cycles (timeout=%0d) required 15", cnt, to);
    end
    $display("convert 10000: raw bcd=%h", bcd);
    @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      n_cmp++;
      if (seg !== 7'h3F || dp !== (an == 4'hE ? 1'b0 : 1'b1) || seg0 !== 7'h3F) begin
        n_bad++;
        $display("FAIL ovf_dash[%0d]: got an=%h seg=%h dp=%b seg0=%h required seg 3F, dp low only on E", i, an, seg, dp, seg0);
      end
    end
  endtask

  task automatic test_mid_change();
    int cnt;
    bit to;
    logic [15:0] exp;
    drive_value(42);
    repeat (5) @(posedge clk);
    #1 regs = 14'd57;
    sb_q.push_back(to_bcd(57));
    wait_done(cnt, to);
    exp = sb_q.pop_front();
    n_cmp++;
    if (to || cnt != 11 || bcd !== exp) begin
      n_bad++;
      $display("FAIL mid_first: got bcd=%h busy=%0d (timeout=%0d) required bcd=%h busy=11", bcd, cnt, to, exp);
    end
    wait_done(cnt, to);
    exp = sb_q.pop_front();
    n_cmp++;
    if (to || cnt != 15 || bcd !== exp) begin
      n_bad++;
      $display("FAIL mid_second: got bcd=%h busy=%0d (timeout=%0d) required bcd=%h busy=15", bcd, cnt, to, exp);
    end
    $display("mid change 42->57: final bcd=%h", bcd);
  endtask

  task automatic test_back_to_back();
    int cnt, v;
    bit to;
    logic [15:0] exp;
    for (int t = 0; t < 4; t++) begin
      do v = $urandom_range(0, 9999); while (v == int'(regs));
      drive_value(v);
      wait_done(cnt, to);
      exp = sb_q.pop_front();
      n_cmp++;
      if (to || bcd !== exp) begin
        n_bad++;
        $display("FAIL b2b_%0d: got %h (timeout=%0d) required %h", v, bcd, to, exp);
      end
      $display("convert %0d: bcd=%h", v, bcd);
    end
  endtask

  task automatic test_reset_mid_shift();
    int cnt;
    bit to;
    logic [15:0] exp;
    logic [29:0] got;
    drive_value(5555);
    repeat (6) @(posedge clk);
    #3 rst_n = 1'b0;
    #1 got = {seg, an, dp, bcd, busy};
    n_cmp++;
    if (got !== {7'h7F, 4'hF, 1'b1, 16'h0000, 1'b0}) begin
      n_bad++;
      $display("FAIL async_reset: got %h required %h", got, {7'h7F, 4'hF, 1'b1, 16'h0000, 1'b0});
    end
    @(negedge clk);
    rst_n = 1'b1;
    wait_done(cnt, to);
    exp = sb_q.pop_front();
    n_cmp++;
    if (to || cnt != 15 || bcd !== exp) begin
      n_bad++;
      $display("FAIL reconvert: got bcd=%h busy=%0d (timeout=%0d) required bcd=%h busy=15", bcd, cnt, to, exp);
    end
    $display("reset mid-shift: reconverted bcd=%h", bcd);
  endtask

  initial begin
    test_reset();
    test_convert_1234();
    test_blank_lz();
    test_overflow();
    test_mid_change();
    test_back_to_back();
    test_reset_mid_shift();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of run required finish before 200000 ns");
    $fatal(1, "watchdog expired");
  end

endmodule
